uart_tx_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter with an internal FIFO. It generalises the fixed 8N1 transmitter with the following features:
- configurable data width, FIFO depth and divisor width;
- runtime baud divisor, parity mode and stop-bit count;
- FIFO occupancy and overflow reporting.

It sits between the packetizer byte stream and the serial pin. Each frame is popped from the FIFO and shifted out LSB-first under `tx_ready` flow control.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 66 ++++++
 rtl/uart_tx_cfg.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks.
// Used by the transmitter and its FIFO.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int MIN_DIV = 2;

   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with registered occupancy flags.
// A write while full is dropped and reported by a one-cycle pulse.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);

   // Storage array; no reset needed, occupancy guards reads.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and the dropped-write pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= wr_en && full;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with input FIFO.
// Frame settings are captured at frame start and held for the frame.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          data_in,
   input  logic                          data_valid,
   input  logic                          tx_ready,
   input  logic [DIV_W-1:0]              baud_div,
   input  logic [1:0]                    parity_mode,
   input  logic                          stop2,
   output logic                          serial_out,
   output logic                          tx_busy,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int BCW = $clog2(DATA_BITS);

   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_START  = START;
   localparam logic [2:0] S_DATA   = DATA;
   localparam logic [2:0] S_PARITY = PARITY;
   localparam logic [2:0] S_STOP   = STOP;

   logic [2:0]           state;
   logic [DIV_W-1:0]     div_cnt;
   logic [DIV_W-1:0]     div_lat;
   logic [BCW-1:0]       bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_acc;
   logic                 par_en;
   logic                 par_odd;
   logic                 stop2_lat;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 pop;
   logic                 bit_tick;
   logic                 last_bit;

   assign pop      = (state == S_IDLE) && !fifo_empty && tx_ready;
   assign bit_tick = (state != S_IDLE) && (div_cnt == div_lat - DIV_W'(1));
   assign last_bit = (bit_cnt == BCW'(DATA_BITS - 1));

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (data_in),
      .wr_en    (data_valid),
      .rd_en    (pop),
      .rd_data  (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count),
      .overflow (overflow)
   );

   // Divisor counter: held at zero in IDLE, wraps on each bit tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (state == S_IDLE || bit_tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Frame sequencer: start, data LSB first, optional parity, stop bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         serial_out <= 1'b1;
         tx_busy    <= 1'b0;
         div_lat    <= DIV_W'(MIN_DIV);
         bit_cnt    <= '0;
         shreg      <= '0;
         par_acc    <= 1'b0;
         par_en     <= 1'b0;
         par_odd    <= 1'b0;
         stop2_lat  <= 1'b0;
      end else begin
         unique case (1'b1)
            (state == S_IDLE): begin
               if (pop) begin
                  state      <= S_START;
                  serial_out <= 1'b0;
                  tx_busy    <= 1'b1;
                  shreg      <= fifo_dout;
                  div_lat    <= (baud_div < DIV_W'(MIN_DIV)) ?
                                DIV_W'(MIN_DIV) : baud_div;
                  par_en     <= par_enabled(parity_mode);
                  par_odd    <= (parity_mode == PAR_ODD);
                  stop2_lat  <= stop2;
                  par_acc    <= 1'b0;
                  bit_cnt    <= '0;
               end
            end
            (state == S_START): begin
               if (bit_tick) begin
                  state      <= S_DATA;
                  serial_out <= shreg[0];
               end
            end
            (state == S_DATA): begin
               if (bit_tick) begin
                  par_acc <= par_acc ^ shreg[0];
                  if (last_bit) begin
                     bit_cnt <= '0;
                     if (par_en) begin
                        state      <= S_PARITY;
                        serial_out <= par_acc ^ shreg[0] ^ par_odd;
                     end else begin
                        state      <= S_STOP;
                        serial_out <= 1'b1;
                     end
                  end else begin
                     shreg      <= shreg >> 1;
                     serial_out <= shreg[1];
                     bit_cnt    <= bit_cnt + BCW'(1);
                  end
               end
            end
            (state == S_PARITY): begin
               if (bit_tick) begin
                  state      <= S_STOP;
                  serial_out <= 1'b1;
                  bit_cnt    <= '0;
               end
            end
            (state == S_STOP): begin
               if (bit_tick) begin
                  if (stop2_lat && bit_cnt == '0) begin
                     bit_cnt <= BCW'(1);
                  end else begin
                     state   <= S_IDLE;
                     tx_busy <= 1'b0;
                  end
               end
            end
            default: begin
               state      <= S_IDLE;
               serial_out <= 1'b1;
               tx_busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg.
// Frames are rebuilt from the character and settings and compared per cycle.
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_in;
   logic        data_valid;
   logic        tx_ready;
   logic [15:0] baud_div;
   logic [1:0]  parity_mode;
   logic        stop2;
   logic        serial_out;
   logic        tx_busy;
   logic        fifo_full;
   logic        fifo_empty;
   logic [4:0]  fifo_count;
   logic        overflow;

   typedef struct {
      logic [7:0] d;
      int         div;
      int         pm;
      bit         s2;
   } exp_t;

   exp_t exp_q[$];
   bit   cap[$];
   int   checks = 0;
   int   failures = 0;
   bit   capturing = 0;
   int   gap = 0;
   bit   chk_gap = 0;
   bit   gap_armed = 0;
   int   ovf_seen = 0;

   always #5 clk = ~clk;

   uart_tx_cfg dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .tx_ready    (tx_ready),
      .baud_div    (baud_div),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .serial_out  (serial_out),
      .tx_busy     (tx_busy),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .fifo_count  (fifo_count),
      .overflow    (overflow)
   );

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   function automatic int clampd(input int d);
      return (d < 2) ? 2 : d;
   endfunction

   // Rebuild the expected line waveform for a character from its settings.
   task automatic finish_frame();
      exp_t e;
      bit   bits[$];
      int   dv;
      int   first;
      bit   expb;
      check("frame_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() == 0) return;
      e  = exp_q.pop_front();
      dv = clampd(e.div);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(e.d[i]);
      if (e.pm == 1) bits.push_back(^e.d);
      if (e.pm == 2) bits.push_back(~^e.d);
      bits.push_back(1'b1);
      if (e.s2) bits.push_back(1'b1);
      check("frame_len", cap.size(), bits.size() * dv);
      first = -1;
      for (int i = 0; i < cap.size(); i++) begin
         expb = (i / dv < bits.size()) ? bits[i / dv] : 1'b1;
         if (cap[i] !== expb && first < 0) first = i;
      end
      check("frame_bits_first_bad_cycle", first, -1);
      if (first >= 0)
         $display("  char=%02h div=%0d pm=%0d s2=%0d", e.d, dv, e.pm, e.s2);
   endtask

   // Monitor: captures each busy window and checks the idle line.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            cap.delete();
            capturing = 0;
            gap = 0;
         end else if (tx_busy) begin
            if (!capturing) begin
               capturing = 1;
               if (chk_gap && gap_armed) check("idle_gap", gap, 1);
               gap_armed = chk_gap;
               cap.delete();
            end
            cap.push_back(serial_out);
         end else begin
            if (capturing) begin
               capturing = 0;
               finish_frame();
               gap = 0;
            end
            gap++;
            if (overflow) ovf_seen++;
            check("idle_line_high", int'(serial_out), 1);
         end
      end
   end

   task automatic write(input logic [7:0] d, input bit accept);
      exp_t e;
      data_in    = d;
      data_valid = 1'b1;
      if (accept) begin
         e.d   = d;
         e.div = int'(baud_div);
         e.pm  = int'(parity_mode);
         e.s2  = stop2;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      data_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while ((exp_q.size() != 0 || tx_busy || !fifo_empty) && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_within_bound", int'(n < bound), 1);
   endtask

   task automatic set_cfg(input int dv, input int pm, input bit s2);
      baud_div    = 16'(dv);
      parity_mode = 2'(pm);
      stop2       = s2;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      rst        = 1'b1;
      data_in    = '0;
      data_valid = 1'b0;
      tx_ready   = 1'b1;
      set_cfg(5, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_serial_out", int'(serial_out), 1);
      check("rst_tx_busy", int'(tx_busy), 0);
      check("rst_fifo_full", int'(fifo_full), 0);
      check("rst_fifo_empty", int'(fifo_empty), 1);
      check("rst_fifo_count", int'(fifo_count), 0);
      check("rst_overflow", int'(overflow), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 0x55 at div 5, no parity, one stop: 50 cycles, checks latency.
      write(8'h55, 1);
      check("lat_fifo_empty_n1", int'(fifo_empty), 0);
      check("lat_fifo_count_n1", int'(fifo_count), 1);
      @(posedge clk);
      #1;
      check("lat_serial_out_n2", int'(serial_out), 0);
      check("lat_tx_busy_n2", int'(tx_busy), 1);
      check("lat_fifo_empty_n2", int'(fifo_empty), 1);
      wait_idle(200);

      set_cfg(5, 1, 0);
      write(8'h07, 1);
      wait_idle(200);
      set_cfg(5, 2, 0);
      write(8'h07, 1);
      wait_idle(200);

      set_cfg(0, 0, 1);
      write(8'hA3, 1);
      wait_idle(200);

      // Fill while blocked, then overfill once.
      set_cfg(2, 0, 0);
      tx_ready = 1'b0;
      ovf_seen = 0;
      for (int i = 0; i < 17; i++) write(8'($urandom), i < 16);
      check("full_overflow_pulse", int'(overflow), 1);
      check("full_fifo_full", int'(fifo_full), 1);
      check("full_fifo_count", int'(fifo_count), 16);
      check("full_serial_out", int'(serial_out), 1);
      check("full_tx_busy", int'(tx_busy), 0);
      @(posedge clk);
      #1;
      check("full_overflow_one_cycle", int'(overflow), 0);
      check("full_overflow_count", ovf_seen, 1);
      chk_gap  = 1;
      tx_ready = 1'b1;
      wait_idle(2000);
      chk_gap  = 0;

      // Reset in the middle of a data bit with characters still queued.
      set_cfg(4, 1, 0);
      write(8'hC3, 1);
      write(8'h11, 1);
      write(8'h22, 1);
      n = 0;
      while (!tx_busy && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rst_test_frame_started", int'(tx_busy), 1);
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_serial_out", int'(serial_out), 1);
      check("midrst_tx_busy", int'(tx_busy), 0);
      check("midrst_fifo_empty", int'(fifo_empty), 1);
      check("midrst_fifo_count", int'(fifo_count), 0);
      @(posedge clk);
      #1;
      write(8'h5A, 1);
      wait_idle(200);

      // Randomised batches, settings constant within a batch.
      for (int b = 0; b < 10; b++) begin
         set_cfg($urandom_range(0, 6), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            write(8'($urandom), 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         wait_idle(1500);
      end

      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
